// File: rtl/series_req_arbiter.sv
// series_req_arbiter
// Round-robin front end that shares one series-expansion calculation unit
// among NREQ requesters. The winner's operand is latched at grant, the unit is
// started once, and its result is returned with a one-cycle ack.
//
// Build option: define ARB_TIMEOUT_EN to add a BUSY-phase watchdog that aborts
// the unit after TIMEOUT_CYCLES cycles without completion and returns err = 1.
// Without it, BUSY waits indefinitely and err/unit_abort stay 0.
//
// state | meaning
// IDLE  | no transaction; on any request latch winner index and its operand
// ISSUE | one-cycle start pulse to the unit with the latched operand
// BUSY  | waiting for unit completion (or watchdog expiry when built in)
// RESP  | one-cycle ack to the winner with result/err; advance priority pointer
module series_req_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned XW             = 16,
    parameter int unsigned RW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*XW-1:0]   x_in_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [RW-1:0]        res_out_o,
    output logic                 err_o,
    output logic                 unit_start_o,
    output logic [XW-1:0]        unit_x_o,
    output logic                 unit_abort_o,
    input  logic                 unit_done_i,
    input  logic [RW-1:0]        unit_res_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
        $error("series_req_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("series_req_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [RW-1:0]   res_q, res_d;
    logic            err_q, err_d;

    logic            win_vld;
    logic [IW-1:0]   win_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Loaded in ISSUE; reaching zero marks the last permitted BUSY cycle.
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0]   tmr_q, tmr_d;
    logic            tmr_tc;

    assign tmr_tc = (tmr_q == '0);
`endif

    // Operand seen by the unit is whatever was latched at the last grant.
    assign unit_x_o = x_q;

    // Round-robin search starting at ptr; walking k downwards lets the
    // candidate closest to ptr overwrite the farther ones.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [IW:0]   cand;
            logic [IW-1:0] cidx;
            cand = {1'b0, ptr_q} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(NREQ)) begin
                cand = cand - (IW + 1)'(NREQ);
            end
            cidx = cand[IW-1:0];
            if (req_i[cidx]) begin
                win_vld = 1'b1;
                win_idx = cidx;
            end
        end
    end

    // Next-state and output decode for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        x_d          = x_q;
        res_d        = res_q;
        err_d        = err_q;
        ack_o        = '0;
        res_out_o    = '0;
        err_o        = 1'b0;
        unit_start_o = 1'b0;
        unit_abort_o = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmr_d        = tmr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d   = win_idx;
                    x_d     = x_in_i[win_idx*XW +: XW];
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                unit_start_o = 1'b1;
`ifdef ARB_TIMEOUT_EN
                tmr_d        = TMR_LOAD;
`endif
                state_d      = S_BUSY;
            end

            S_BUSY: begin
                // Completion takes precedence over a coinciding watchdog expiry.
                if (unit_done_i) begin
                    res_d   = unit_res_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmr_tc) begin
                    unit_abort_o = 1'b1;
                    res_d        = '0;
                    err_d        = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end

            S_RESP: begin
                ack_o[gnt_q] = 1'b1;
                res_out_o    = res_q;
                err_o        = err_q;
                ptr_d        = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            x_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            x_q     <= x_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog down-counter, only meaningful while BUSY.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

endmodule

// File: doc/series_req_arbiter.md
# series_req_arbiter

Round-robin scheduler that shares one series-expansion calculation unit (x/x² load, LUT multiply and add/sub sequencing controller plus datapath) among NREQ requesters. Each requester presents an operand x under a req/ack handshake. The arbiter grants one requester at a time, issues a start pulse to the unit, waits for unit completion, and returns the result with a one-cycle ack. It sits between the client blocks and the calculation unit's top level.

## Interface
- NREQ, 4, number of requesters (2..8)
- XW, 16, operand width
- RW, 32, result width
- TIMEOUT_CYCLES, 64, BUSY-cycle limit; used only with ARB_TIMEOUT_EN
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-low (0 = reset)
- req  in  NREQ  per-requester request level
- x_in  in  NREQ*XW  operands; requester i at bits [i*XW +: XW]
- ack  out  NREQ  one-hot, one-cycle result-valid pulse to granted requester
- res_out  out  RW  result; valid only while any ack bit = 1
- err  out  1  timeout flag; valid with ack
- unit_start  out  1  one-cycle start pulse to calculation unit
- unit_x  out  XW  operand to unit; held stable from ISSUE until next grant
- unit_abort  out  1  one-cycle abort pulse to unit on timeout
- unit_done  in  1  unit completion pulse
- unit_res  in  RW  unit result; sampled when unit_done = 1 in BUSY

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP.
- Priority pointer ptr (0..NREQ-1) marks the highest-priority index. Search order: ptr, ptr+1, … wrapping mod NREQ.
- IDLE: if any req bit = 1, latch winner index g and x_in slice g into x_reg, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: unit_start = 1; unit_x = x_reg; clear timeout counter; go to BUSY.
- BUSY: on unit_done = 1, capture unit_res into res_reg, err_reg = 0, go to RESP. unit_done in any other state is ignored.
- RESP: ack[g] = 1, res_out = res_reg, err = err_reg; ptr <= (g+1) mod NREQ; go to IDLE.
- Requester contract: hold req and x_in constant until ack is seen. Deassert req on the same clock edge that samples ack high. Changing req or x_in after grant has no effect on the transaction in flight.
- No cancellation: a req drop during ISSUE/BUSY still produces ack to g.
- A single requester with req held continuously is served back-to-back. With multiple requesters active, each waits at most NREQ-1 transactions.

## Timing
- Reset (rst = 0 at edge): state = IDLE, ptr = 0, x_reg = 0, res_reg = 0, err_reg = 0. All outputs are 0: ack, res_out, err, unit_start, unit_x, unit_abort.
- Reset mid-transaction: abandon the transaction, no ack. Unit state is the unit's own reset concern.
- res_out and err are driven 0 whenever ack = 0.
- unit_start is high for exactly one cycle per grant. unit_done is accepted from the cycle after ISSUE onward.
- Latency: req sampled in IDLE at edge E → ISSUE in cycle E+1 → BUSY from E+2. If unit_done arrives in cycle E+1+L (L ≥ 1), ack is high in cycle E+2+L.
- Minimum req→ack gap with unit_done in the first BUSY cycle: ack in the 3rd cycle after grant edge.
- The next grant can be made in the IDLE cycle immediately after RESP, so there is one idle cycle between transactions.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined: a counter runs in BUSY. If TIMEOUT_CYCLES BUSY cycles elapse without unit_done, then in that last cycle unit_abort = 1 for one cycle, res_reg = 0, err_reg = 1, and the FSM goes to RESP. If unit_done and expiry coincide, done wins (err = 0, real result).
- Undefined: no counter; BUSY waits indefinitely; err and unit_abort tied to 0.

## Test plan
- Reset, then req = 0001, x_in[0] = 0x0100; unit model returns 0x0000_1234 with L = 5 → one unit_start with unit_x = 0x0100; ack = 0001 exactly 7 cycles after grant edge; res_out = 0x1234; err = 0.
- req = 1011 held, each requester dropping req after its ack → grant order 0, 1, 3; ptr = 0 after the third ack; no requester served twice.
- Requester 2 drops req during BUSY → ack[2] still pulses with the unit result; the next grant goes to the next active index after 2.
- rst = 0 for one edge while in BUSY → no ack. Next cycle: all outputs 0, ptr = 0. A new req = 0100 is served normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, unit never completes → unit_abort pulse in the 8th BUSY cycle; ack next cycle with err = 1, res_out = 0.
- ARB_TIMEOUT_EN, unit_done in the 8th BUSY cycle → no abort; err = 0; res_out = unit_res.
